// File: rtl/comm_pkg.sv
// Shared types and sizing helpers for the command-link master and its UART.
package comm_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_TX, WAIT_RESP} state_t;

  localparam int CMD_W = 8;

  function automatic int frame_w(input int data_w);
    return CMD_W + data_w;
  endfunction

  function automatic int bytes_of(input int data_w);
    return data_w / 8 + 1;
  endfunction

endpackage

// File: rtl/comm_uart.sv
// 8N1 UART transmitter and receiver sharing one baud divisor.
module comm_uart
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trmt,
  input  logic [CMD_W-1:0] tx_data,
  output logic             tx_done,
  output logic             TX,
  input  logic             RX,
  output logic [CMD_W-1:0] rx_data,
  output logic             rx_rdy,
  input  logic             clr_rx_rdy
);

  localparam int BW = $clog2(BAUD_DIV);

  logic [9:0]    tx_sh;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic          tx_act;

  assign TX = tx_sh[0];

  // Idle shift register is all ones so TX rests high and stop bits shift in free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_act  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !tx_act) begin
        tx_sh   <= {1'b1, tx_data, 1'b0};
        tx_cnt  <= '0;
        tx_bits <= '0;
        tx_act  <= 1'b1;
      end else if (tx_act) begin
        if (tx_cnt == BW'(BAUD_DIV - 1)) begin
          tx_cnt <= '0;
          tx_sh  <= {1'b1, tx_sh[9:1]};
          if (tx_bits == 4'd9) begin
            tx_act  <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            tx_bits <= tx_bits + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  logic          rx_ff1, rx_s;
  logic [BW-1:0] rx_cnt;
  logic [3:0]    rx_bits;
  logic          rx_act;
  logic [7:0]    rx_sh;

  // rx_bits: 0 = validating start at mid-bit, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      rx_cnt  <= '0;
      rx_bits <= '0;
      rx_act  <= 1'b0;
      rx_sh   <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
    end else begin
      rx_ff1 <= RX;
      rx_s   <= rx_ff1;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_act) begin
        if (!rx_s) begin
          rx_act  <= 1'b1;
          rx_cnt  <= '0;
          rx_bits <= '0;
        end
      end else if (rx_bits == 4'd0) begin
        if (rx_cnt == BW'(BAUD_DIV / 2 - 1)) begin
          rx_cnt <= '0;
          if (rx_s) rx_act  <= 1'b0;
          else      rx_bits <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt == BW'(BAUD_DIV - 1)) begin
        rx_cnt <= '0;
        if (rx_bits <= 4'd8) begin
          rx_sh   <= {rx_s, rx_sh[7:1]};
          rx_bits <= rx_bits + 4'd1;
        end else begin
          rx_act  <= 1'b0;
          rx_data <= rx_sh;
          rx_rdy  <= 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/comm_master_frm.sv
// Command-link master: sends {cmd, data} as UART bytes, waits for a one-byte reply, retries on timeout.
module comm_master_frm
  import comm_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int RETRIES     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snd_cmd,
  input  logic [7:0]        cmd,
  input  logic [DATA_W-1:0] data,
  input  logic              RX,
  output logic              TX,
  output logic              busy,
  output logic              frm_snt,
  output logic [7:0]        resp,
  output logic              resp_rdy,
  input  logic              clr_resp_rdy,
  output logic              timeout
);

  localparam int FW = frame_w(DATA_W);
  localparam int NB = bytes_of(DATA_W);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

  state_t        state, state_nxt;
  logic [FW-1:0] frame;
  logic [3:0]    idx;
  logic [RW-1:0] retry;
  logic [TW-1:0] tcnt;
  logic [7:0]    tx_data, rx_data;
  logic          trmt, tx_done, rx_rdy, clr_rx_rdy;
  logic          accept, inc_idx, inc_retry, set_to;

  comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .TX         (TX),
    .RX         (RX),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy)
  );

  // Every received byte is consumed immediately into resp.
  assign clr_rx_rdy = rx_rdy;
  assign busy       = (state != IDLE);

  // Byte 0 is the command, then the payload MSB byte first.
  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NB; i++)
      if (idx == 4'(i)) tx_data = frame[FW - CMD_W * (i + 1) +: CMD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    trmt      = 1'b0;
    inc_idx   = 1'b0;
    inc_retry = 1'b0;
    set_to    = 1'b0;
    frm_snt   = 1'b0;
    case (state)
      IDLE: if (snd_cmd) begin
        accept    = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        trmt      = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: if (tx_done) begin
        if (idx < 4'(NB - 1)) begin
          inc_idx   = 1'b1;
          state_nxt = SEND;
        end else begin
          frm_snt   = 1'b1;
          state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (rx_rdy) begin
          state_nxt = IDLE;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          if (int'(retry) < RETRIES) begin
            inc_retry = 1'b1;
            state_nxt = LOAD;
          end else begin
            set_to    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      retry    <= '0;
      tcnt     <= '0;
      timeout  <= 1'b0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      if (state == LOAD) idx <= '0;
      else if (inc_idx)  idx <= idx + 4'd1;
      if (accept)         retry <= '0;
      else if (inc_retry) retry <= retry + 1'b1;
      if (frm_snt)                 tcnt <= '0;
      else if (state == WAIT_RESP) tcnt <= tcnt + 1'b1;
      if (accept)      timeout <= 1'b0;
      else if (set_to) timeout <= 1'b1;
      if (rx_rdy) begin
        resp     <= rx_data;
        resp_rdy <= 1'b1;
      end else if (clr_resp_rdy) begin
        resp_rdy <= 1'b0;
      end
    end
  end

  // Frame holds across retries; only an accepted request reloads it.
  always_ff @(posedge clk) begin
    if (accept) frame <= {cmd, data};
  end

endmodule

// File: tb/tb_comm_master_frm.sv
// Directed bench for comm_master_frm with 16- and 32-bit payload instances and a behavioural far end.
module tb_comm_master_frm;

  localparam int B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        snd16, clr16, rx16;
  logic [7:0]  cmd16;
  logic [15:0] data16;
  logic        tx16, busy16, frm16, rdy16, to16;
  logic [7:0]  resp16;

  logic        snd32, clr32, rx32;
  logic [7:0]  cmd32;
  logic [31:0] data32;
  logic        tx32, busy32, frm32, rdy32, to32;
  logic [7:0]  resp32;

  comm_master_frm #(.DATA_W(16), .BAUD_DIV(B), .TIMEOUT_CYC(1000), .RETRIES(2)) u16 (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd16), .cmd(cmd16), .data(data16), .RX(rx16), .TX(tx16),
    .busy(busy16), .frm_snt(frm16), .resp(resp16), .resp_rdy(rdy16), .clr_resp_rdy(clr16),
    .timeout(to16)
  );

  comm_master_frm #(.DATA_W(32), .BAUD_DIV(B), .TIMEOUT_CYC(200), .RETRIES(1)) u32 (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd32), .cmd(cmd32), .data(data32), .RX(rx32), .TX(tx32),
    .busy(busy32), .frm_snt(frm32), .resp(resp32), .resp_rdy(rdy32), .clr_resp_rdy(clr32),
    .timeout(to32)
  );

  int checks = 0, failures = 0;
  int cyc = 0, nfrm16 = 0, nfrm32 = 0, last_frm16 = 0, last_frm32 = 0, req32 = 0;
  logic [7:0] q16[$];
  logic [7:0] q32[$];
  logic [7:0] e32 [5] = '{8'h93, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frm16) begin nfrm16 <= nfrm16 + 1; last_frm16 <= cyc + 1; end
    if (frm32) begin nfrm32 <= nfrm32 + 1; last_frm32 <= cyc + 1; end
  end

  // Far-end receivers: decode 8N1 bytes off each TX line.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx16);
      repeat (B / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin repeat (B) @(posedge clk); b[i] = tx16; end
      repeat (B) @(posedge clk);
      q16.push_back(b);
    end
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx32);
      repeat (B / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin repeat (B) @(posedge clk); b[i] = tx32; end
      repeat (B) @(posedge clk);
      q32.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd16(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    cmd16 = c; data16 = d; snd16 = 1'b1;
    @(negedge clk);
    snd16 = 1'b0;
  endtask

  task automatic send_cmd32(input logic [7:0] c, input logic [31:0] d);
    @(negedge clk);
    cmd32 = c; data32 = d; snd32 = 1'b1; req32 = cyc;
    @(negedge clk);
    snd32 = 1'b0;
  endtask

  task automatic send_byte16(input logic [7:0] b);
    rx16 = 1'b0; repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx16 = b[i]; repeat (B) @(negedge clk); end
    rx16 = 1'b1; repeat (B) @(negedge clk);
  endtask

  task automatic wait_frm16(input int target, input int budget);
    for (int i = 0; i < budget && nfrm16 < target; i++) @(negedge clk);
    chk("frm16_count", 64'(nfrm16), 64'(target));
  endtask

  task automatic wait_idle16(input int budget);
    for (int i = 0; i < budget && busy16; i++) @(negedge clk);
    chk("idle16", 64'(busy16), 64'd0);
  endtask

  task automatic wait_frm32(input int target, input int budget);
    for (int i = 0; i < budget && nfrm32 < target; i++) @(negedge clk);
    chk("frm32_count", 64'(nfrm32), 64'(target));
  endtask

  task automatic wait_idle32(input int budget);
    for (int i = 0; i < budget && busy32; i++) @(negedge clk);
    chk("idle32", 64'(busy32), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lat;
    rst_n = 1'b0;
    snd16 = 1'b0; clr16 = 1'b0; rx16 = 1'b1; cmd16 = '0; data16 = '0;
    snd32 = 1'b0; clr32 = 1'b0; rx32 = 1'b1; cmd32 = '0; data32 = '0;
    repeat (4) @(negedge clk);
    chk("rst_tx", 64'(tx16), 64'd1);
    chk("rst_busy", 64'(busy16), 64'd0);
    chk("rst_frm", 64'(frm16), 64'd0);
    chk("rst_resp", 64'(resp16), 64'h00);
    chk("rst_rdy", 64'(rdy16), 64'd0);
    chk("rst_to", 64'(to16), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame with response; a second request while busy is ignored.
    q16.delete();
    send_cmd16(8'h43, 16'h0076);
    chk("busy_rise", 64'(busy16), 64'd1);
    send_cmd16(8'hFF, 16'h1234);
    wait_frm16(1, 1000);
    chk("t1_nbytes", 64'(q16.size()), 64'd3);
    chk("t1_b0", 64'(q16[0]), 64'h43);
    chk("t1_b1", 64'(q16[1]), 64'h00);
    chk("t1_b2", 64'(q16[2]), 64'h76);
    clr16 = 1'b1;
    fork send_byte16(8'hA5); join_none
    wait_idle16(1000);
    chk("t1_rdy_set_wins", 64'(rdy16), 64'd1);
    clr16 = 1'b0;
    @(negedge clk);
    chk("t1_rdy_hold", 64'(rdy16), 64'd1);
    chk("t1_resp", 64'(resp16), 64'hA5);
    chk("t1_to", 64'(to16), 64'd0);
    chk("t1_one_frame", 64'(nfrm16), 64'd1);
    repeat (2 * B) @(negedge clk);
    clr16 = 1'b1; @(negedge clk); clr16 = 1'b0; @(negedge clk);
    chk("t1_rdy_clr", 64'(rdy16), 64'd0);

    // Silent slave: three identical frames, then timeout.
    q16.delete();
    base = nfrm16;
    send_cmd16(8'h11, 16'hBEEF);
    wait_idle16(8000);
    chk("t3_frames", 64'(nfrm16 - base), 64'd3);
    chk("t3_to", 64'(to16), 64'd1);
    chk("t3_to_delay", 64'(cyc - last_frm16), 64'd1000);
    chk("t3_nbytes", 64'(q16.size()), 64'd9);
    for (int i = 0; i < 3; i++) begin
      chk("t3_cmd", 64'(q16[3*i]), 64'h11);
      chk("t3_hi", 64'(q16[3*i+1]), 64'hBE);
      chk("t3_lo", 64'(q16[3*i+2]), 64'hEF);
    end

    // Reply during the second wait: one retry, no timeout.
    base = nfrm16;
    send_cmd16(8'h22, 16'h3344);
    chk("t4_to_cleared", 64'(to16), 64'd0);
    wait_frm16(base + 2, 3000);
    send_byte16(8'h5A);
    wait_idle16(1000);
    chk("t4_frames", 64'(nfrm16 - base), 64'd2);
    chk("t4_resp", 64'(resp16), 64'h5A);
    chk("t4_rdy", 64'(rdy16), 64'd1);
    chk("t4_to", 64'(to16), 64'd0);

    // Reset during the second byte, then a clean frame.
    q16.delete();
    base = nfrm16;
    send_cmd16(8'h55, 16'h6677);
    for (int i = 0; i < 500 && q16.size() < 1; i++) @(negedge clk);
    repeat (3 * B) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 64'(tx16), 64'd1);
    chk("mid_rst_busy", 64'(busy16), 64'd0);
    chk("mid_rst_frm", 64'(frm16), 64'd0);
    chk("mid_rst_resp", 64'(resp16), 64'h00);
    chk("mid_rst_rdy", 64'(rdy16), 64'd0);
    chk("mid_rst_to", 64'(to16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * B) @(negedge clk);
    chk("abort_no_frm", 64'(nfrm16), 64'(base));
    q16.delete();
    send_cmd16(8'h66, 16'h789A);
    wait_frm16(base + 1, 1000);
    chk("t6_nbytes", 64'(q16.size()), 64'd3);
    chk("t6_b0", 64'(q16[0]), 64'h66);
    chk("t6_b1", 64'(q16[1]), 64'h78);
    chk("t6_b2", 64'(q16[2]), 64'h9A);

    // 32-bit payload: byte order, frame latency, one retry then timeout.
    q32.delete();
    send_cmd32(8'h93, 32'hDEADBEEF);
    wait_frm32(1, 2000);
    lat = last_frm32 - req32;
    chk("t2_latency_window", 64'(lat >= 50 * B - 20 && lat <= 50 * B + 20), 64'd1);
    chk("t2_nbytes", 64'(q32.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("t2_byte", 64'(q32[i]), 64'(e32[i]));
    wait_idle32(3000);
    chk("t2_frames", 64'(nfrm32), 64'd2);
    chk("t2_to", 64'(to32), 64'd1);
    chk("t2_retry_nbytes", 64'(q32.size()), 64'd10);
    for (int i = 0; i < 5; i++) chk("t2_retry_byte", 64'(q32[i+5]), 64'(e32[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comm_master_frm.md
# comm_master_frm

Parametrised command-link master for the remote-control side of the design. It serialises an 8-bit command plus a DATA_W-bit payload as (1 + DATA_W/8) back-to-back UART bytes on TX, then waits for a one-byte response on RX. A configurable response timeout with automatic frame retransmission is the new capability. It is the generalised successor to the fixed 8+16-bit command master and pairs with the existing UART wrapper on the far end.

## Interface
- DATA_W, 16, payload width in bits; multiple of 8, range 8..64
- BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200)
- TIMEOUT_CYC, 1048576, clk cycles to wait for a response after a frame completes; ≥ 2
- RETRIES, 2, extra frame transmissions after the first on timeout; 0 disables retry
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- snd_cmd  in  1  one-cycle request to send; sampled only when busy=0
- cmd  in  8  command byte, latched on accepted snd_cmd
- data  in  DATA_W  payload, latched on accepted snd_cmd
- RX  in  1  serial input from slave, idle high, 8N1
- TX  out  1  serial output to slave, idle high, 8N1
- busy  out  1  high from accepted snd_cmd until response or final timeout
- frm_snt  out  1  one-cycle pulse when the stop bit of a frame's last byte completes
- resp  out  8  last received response byte
- resp_rdy  out  1  set on byte received; cleared by clr_resp_rdy
- clr_resp_rdy  in  1  clears resp_rdy
- timeout  out  1  sticky: set when all retries have expired; cleared by next accepted snd_cmd

## Operation
- FSM states: IDLE, LOAD, SEND, WAIT_TX, WAIT_RESP.
- IDLE: busy=0. snd_cmd=1 latches {cmd, data} into a (8+DATA_W)-bit frame register, clears timeout, zeroes the retry counter, and moves to LOAD. snd_cmd while busy=1 is ignored (no latch, no queue).
- LOAD: byte index ← 0 → SEND.
- SEND: issue one trmt pulse for frame byte[index]; bytes go command first, then payload MSB-byte first → WAIT_TX.
- WAIT_TX: on tx_done, if index < DATA_W/8, then index+1 → SEND; otherwise pulse frm_snt, clear the timeout counter → WAIT_RESP.
- WAIT_RESP: counter increments each cycle. On rx byte → IDLE. On count == TIMEOUT_CYC-1: if retry count < RETRIES, then retry+1 → LOAD (same latched frame); otherwise set timeout → IDLE.
- Response capture runs in every state. Any received byte loads resp and sets resp_rdy. Only in WAIT_RESP does it end the wait. If a byte arrives in the same cycle as clr_resp_rdy, set wins.
- Rx byte and timeout expiry in the same WAIT_RESP cycle: the response wins, no retry, timeout stays 0.
- Frame register contents are stable for all retries; changes on cmd/data while busy have no effect.

## Timing
- Reset values: TX=1, busy=0, frm_snt=0, resp=8'h00, resp_rdy=0, timeout=0, FSM=IDLE, counters=0.
- Reset asserted mid-frame forces TX high immediately (async) and aborts with no frm_snt.
- busy rises the cycle after the snd_cmd sample edge.
- Each byte occupies exactly 10×BAUD_DIV cycles on TX. Overhead between consecutive bytes is ≤ 3 cycles.
- Frame length ≈ (1+DATA_W/8)×10×BAUD_DIV cycles. frm_snt is high for exactly 1 cycle per transmitted frame, including retries.
- Timeout fires TIMEOUT_CYC cycles after frm_snt. busy falls the cycle after the response byte's stop-bit sample, or the cycle timeout is set.
- RX is double-flopped before use. A start bit is validated at mid-bit (BAUD_DIV/2).

## Structure
- Shared package comm_pkg: state enum, CMD_W=8 constant, frame-width function (8+DATA_W), and a BYTES=DATA_W/8+1 localparam helper.
- One sub-module: comm_uart (8N1 transmitter and receiver, parameter BAUD_DIV). Its ports are trmt/tx_data/tx_done and rx_data/rx_rdy/clr_rx_rdy.
- The top level holds the FSM, frame register, byte index, retry counter, timeout counter ($clog2(TIMEOUT_CYC) bits), and response capture.

## Test plan
- DATA_W=16, cmd=8'h43, data=16'h0076 with a loopback UART_wrapper: bytes 43,00,76 appear on TX. The far end reports cmd=43 and data=0076 at frm_snt. The slave responds A5, which gives resp=A5, resp_rdy=1, busy=0, timeout=0.
- DATA_W=32, cmd=8'h93, data=32'hDEADBEEF: TX carries 93,DE,AD,BE,EF in order. frm_snt pulses once, 50×BAUD_DIV cycles (±20) after the request.
- RETRIES=2, TIMEOUT_CYC=1000, silent slave: exactly 3 frm_snt pulses, each frame identical. timeout=1 after the third wait, and busy=0.
- Slave silent on the first frame and replies 5A during the second wait: 2 frm_snt pulses, resp=5A, timeout=0.
- snd_cmd with cmd=8'hFF pulsed again while busy: ignored, and the original frame is sent unchanged. clr_resp_rdy on the same cycle as an rx byte leaves resp_rdy=1.
- rst_n low during the second byte: TX=1 and all outputs return to their reset values immediately. A new snd_cmd then produces a complete, correct frame.
